// File: rtl/alu_pkg.sv
// Shared ALU op encodings and widths.
// Used by the issue stage, the ALU and benches.
package alu_pkg;

   localparam int OP_W = 2;

   typedef logic [OP_W-1:0] alu_op_t;

   localparam alu_op_t OP_ADD = 2'b00;
   localparam alu_op_t OP_SUB = 2'b01;
   localparam alu_op_t OP_AND = 2'b10;
   localparam alu_op_t OP_OR  = 2'b11;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: op input, ALU drive,
// ALU return and result handshake.
interface alu_issue_stage_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 3
);
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   alu_op_t          in_op;
   logic [AW-1:0]    in_rd;
   logic [AW-1:0]    in_rs1;
   logic [AW-1:0]    in_rs2;
   logic             in_imm_en;
   logic [WIDTH-1:0] in_imm;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   alu_op_t          alu_sel;
   logic [WIDTH-1:0] alu_result;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [AW-1:0]    res_rd;

   modport slave (
      input  in_valid, in_op, in_rd,
      input  in_rs1, in_rs2,
      input  in_imm_en, in_imm,
      input  alu_result, res_ready,
      output in_ready,
      output alu_a, alu_b, alu_sel,
      output res_valid, res_data, res_rd
   );

   modport master (
      output in_valid, in_op, in_rd,
      output in_rs1, in_rs2,
      output in_imm_en, in_imm,
      output alu_result, res_ready,
      input  in_ready,
      input  alu_a, alu_b, alu_sel,
      input  res_valid, res_data, res_rd
   );

endinterface

// File: rtl/alu_regfile.sv
// NREG x WIDTH register file, r0 hardwired zero.
// Two combinational reads, one synchronous write.
module alu_regfile #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   localparam int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wdata
);

   logic [WIDTH-1:0] mem [NREG];

   assign rdata1 = (ra1 == '0) ? '0 : mem[ra1];
   assign rdata2 = (ra2 == '0) ? '0 : mem[ra2];

   // Storage; writes to r0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            mem[i] <= '0;
      end else if (we && wa != '0) begin
         mem[wa] <= wdata;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch / issue stage feeding the ALU.
// Macro ALU_ISSUE_FORWARD_EN: forward EX result.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREG  = 8
) (
   input logic clk,
   input logic rst_n,
   alu_issue_stage_if.slave bus
);

   localparam int AW = $clog2(NREG);

   logic             ex_valid;
   logic [WIDTH-1:0] ex_a;
   logic [WIDTH-1:0] ex_b;
   alu_op_t          ex_sel;
   logic [AW-1:0]    ex_rd;

   logic [WIDTH-1:0] rf1;
   logic [WIDTH-1:0] rf2;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             ex_live;
   logic             hit1;
   logic             hit2;
   logic             stall;
   logic             ready;
   logic             accept;
   logic             retire;

   alu_regfile #(
      .WIDTH(WIDTH),
      .NREG (NREG)
   ) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (bus.in_rs1),
      .ra2   (bus.in_rs2),
      .rdata1(rf1),
      .rdata2(rf2),
      .we    (retire),
      .wa    (ex_rd),
      .wdata (bus.alu_result)
   );

   // EX holds a real destination; r0 never hazards.
   assign ex_live = ex_valid && ex_rd != '0;
   assign hit1    = ex_live && ex_rd == bus.in_rs1;
   assign hit2    = ex_live && ex_rd == bus.in_rs2
                 && !bus.in_imm_en;

`ifdef ALU_ISSUE_FORWARD_EN
   // Accept with EX busy implies retire this edge,
   // so the live ALU output is the correct value.
   assign stall = 1'b0;
   assign opa   = hit1 ? bus.alu_result : rf1;
   assign opb   = bus.in_imm_en ? bus.in_imm
                : hit2 ? bus.alu_result : rf2;
`else
   // Wait one bubble for writeback, then read.
   assign stall = hit1 || hit2;
   assign opa   = rf1;
   assign opb   = bus.in_imm_en ? bus.in_imm : rf2;
`endif

   assign ready  = (!ex_valid || bus.res_ready)
                && !stall;
   assign accept = bus.in_valid && ready;
   assign retire = ex_valid && bus.res_ready;

   // EX slot: load on accept, drain on retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_sel   <= OP_ADD;
         ex_rd    <= '0;
      end else if (accept) begin
         ex_valid <= 1'b1;
         ex_a     <= opa;
         ex_b     <= opb;
         ex_sel   <= bus.in_op;
         ex_rd    <= bus.in_rd;
      end else if (retire) begin
         ex_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.alu_a     = ex_a;
   assign bus.alu_b     = ex_b;
   assign bus.alu_sel   = ex_sel;
   assign bus.res_valid = ex_valid;
   assign bus.res_data  = bus.alu_result;
   assign bus.res_rd    = ex_rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases and
// random traffic against a transaction-level model.
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.WIDTH(16), .AW(3)) bus ();

   alu_issue_stage #(.WIDTH(16), .NREG(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [15:0] alu_fn(
      input logic [1:0] op,
      input logic [15:0] a,
      input logic [15:0] b
   );
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         default: return a | b;
      endcase
   endfunction

   assign bus.alu_result =
      alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

   typedef struct packed {
      logic [2:0]  rd;
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
   } ex_t;

   ex_t         q[$];
   logic [15:0] mregs [8];

   int checks = 0;
   int failures = 0;

   logic        v, rr, ie;
   logic [1:0]  op;
   logic [2:0]  rd, rs1, rs2;
   logic [15:0] imm;
   logic        accepted;
   logic        want_en = 1'b0;
   logic [15:0] want;

   task automatic check(
      input string tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 8; i++) mregs[i] = '0;
   endtask

   task automatic step();
      logic stl, er, acc, ret;
      ex_t  e, n;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_imm_en = ie;
      bus.in_imm    = imm;
      bus.res_ready = rr;
      #1;
      stl = 1'b0;
`ifndef ALU_ISSUE_FORWARD_EN
      if (q.size() != 0 && q[0].rd != 0 &&
          (rs1 == q[0].rd ||
           (!ie && rs2 == q[0].rd)))
         stl = 1'b1;
`endif
      er = (q.size() == 0 || rr) && !stl;
      check("in_ready", 32'(bus.in_ready), 32'(er));
      check("res_valid", 32'(bus.res_valid),
            32'(q.size() != 0));
      if (q.size() != 0) begin
         e = q[0];
         check("alu_a", 32'(bus.alu_a), 32'(e.a));
         check("alu_b", 32'(bus.alu_b), 32'(e.b));
         check("alu_sel", 32'(bus.alu_sel), 32'(e.op));
         check("res_rd", 32'(bus.res_rd), 32'(e.rd));
         check("res_data", 32'(bus.res_data), 32'(e.r));
         if (want_en)
            check("res_lit", 32'(bus.res_data),
                  32'(want));
      end else if (want_en) begin
         check("res_lit_missing", 0, 1);
      end
      want_en = 1'b0;
      acc = v && er;
      ret = (q.size() != 0) && rr;
      @(posedge clk);
      if (ret) begin
         e = q.pop_front();
         if (e.rd != 0) mregs[e.rd] = e.r;
      end
      if (acc) begin
         n.rd = rd;
         n.op = op;
         n.a  = (rs1 == 0) ? 16'h0 : mregs[rs1];
         n.b  = ie ? imm
              : (rs2 == 0) ? 16'h0 : mregs[rs2];
         n.r  = alu_fn(op, n.a, n.b);
         q.push_back(n);
      end
      accepted = acc;
   endtask

   task automatic issue(
      input logic [1:0]  o,
      input logic [2:0]  d,
      input logic [2:0]  s1,
      input logic [2:0]  s2,
      input logic        i_en,
      input logic [15:0] i_val,
      input logic [15:0] expv,
      output int         waits
   );
      v = 1'b1; op = o; rd = d;
      rs1 = s1; rs2 = s2; ie = i_en; imm = i_val;
      waits = 0;
      step();
      while (!accepted && waits < 20) begin
         waits++;
         step();
      end
      if (!accepted) check("issue_timeout", 0, 1);
      v = 1'b0;
      want_en = 1'b1;
      want = expv;
   endtask

   task automatic idle(input int n);
      v = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   int w;

   initial begin
      v = 0; rr = 1; ie = 0; op = 0;
      rd = 0; rs1 = 0; rs2 = 0; imm = 0;
      model_reset();
      bus.in_valid = 0;
      bus.res_ready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 16'h1234,
            16'h1234, w);
      idle(1);
      check("r1_after", 32'(mregs[1]), 32'h1234);

      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 16'h00FF,
            16'h00FF, w);
      issue(OP_SUB, 3'd2, 3'd1, 3'd0, 1, 16'h0001,
            16'h00FE, w);
`ifdef ALU_ISSUE_FORWARD_EN
      check("fwd_waits", 32'(w), 0);
`else
      check("stall_waits", 32'(w), 1);
`endif
      idle(1);

      rr = 1'b0;
      issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1, 16'h0A0A,
            16'h0A0A, w);
      idle(3);
      check("r6_held", 32'(mregs[6]), 0);
      rr = 1'b1;
      idle(1);
      issue(OP_ADD, 3'd0, 3'd6, 3'd0, 1, 16'h0000,
            16'h0A0A, w);

      issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1, 16'h0005,
            16'h0005, w);
      idle(1);
      issue(OP_OR, 3'd5, 3'd0, 3'd0, 0, 16'h0000,
            16'h0000, w);

      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 16'hFFFF,
            16'hFFFF, w);
      issue(OP_ADD, 3'd3, 3'd1, 3'd0, 1, 16'h0001,
            16'h0000, w);
      issue(OP_SUB, 3'd4, 3'd0, 3'd1, 0, 16'h0000,
            16'h0001, w);
      issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1, 16'hF0F0,
            16'hF0F0, w);
      issue(OP_AND, 3'd5, 3'd1, 3'd0, 1, 16'h0FF0,
            16'h00F0, w);
      issue(OP_OR, 3'd6, 3'd1, 3'd0, 1, 16'h0F0F,
            16'hFFFF, w);
      idle(1);

      rr = 1'b0;
      issue(OP_ADD, 3'd7, 3'd0, 3'd0, 1, 16'h7777,
            16'h7777, w);
      idle(1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_res_valid", 32'(bus.res_valid), 0);
      check("rst_in_ready", 32'(bus.in_ready), 1);
      check("rst_alu_a", 32'(bus.alu_a), 0);
      check("rst_res_rd", 32'(bus.res_rd), 0);
      model_reset();
      rr = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      for (int k = 1; k < 8; k++) begin
         issue(OP_OR, 3'd0, 3'(k), 3'(k), 0,
               16'h0000, 16'h0000, w);
      end
      idle(1);

      for (int c = 0; c < 600; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         rr  = ($urandom_range(0, 3) != 0);
         op  = 2'($urandom_range(0, 3));
         rd  = 3'($urandom_range(0, 7));
         rs1 = 3'($urandom_range(0, 7));
         rs2 = 3'($urandom_range(0, 7));
         ie  = ($urandom_range(0, 1) != 0);
         case ($urandom_range(0, 3))
            0:       imm = 16'hFFFF;
            1:       imm = 16'h0001;
            default: imm = 16'($urandom());
         endcase
         step();
      end
      rr = 1'b1;
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
